// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  // Writeback select value that marks a load.
  localparam logic [1:0] WB_MEM = 2'b01;

  // Architectural zero register; never a real hazard source.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Level of rst that holds the block in reset.
  localparam logic RESET = 1'b0;

  // Data-bus access FSM.
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of hazard inputs, data-bus handshake and stage controls.
// Latency: n/a (wires only).
// Backpressure: dbusReq/dbusAck handshake; master is the controller.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);

  logic [4:0]       idRs1Addr;
  logic [4:0]       idRs2Addr;
  logic             idRs1Used;
  logic             idRs2Used;
  logic [4:0]       exRdAddr;
  logic             exRwen;
  logic [1:0]       exWbSel;
  logic             exPcSel;
  logic             memMwen;
  logic [1:0]       memWbSel;
  logic             dbusAck;
  logic             stallCntClr;
  logic             dbusReq;
  logic             dbusErr;
  logic             pcStall;
  logic             ifIdStall;
  logic             ifIdFlush;
  logic             idExStall;
  logic             idExFlush;
  logic             exMemStall;
  logic             memWbFlush;
  logic [CNT_W-1:0] stallCnt;

  // Controller side: consumes pipeline state, drives stage controls.
  modport master (
    input  idRs1Addr, idRs2Addr, idRs1Used, idRs2Used,
    input  exRdAddr, exRwen, exWbSel, exPcSel,
    input  memMwen, memWbSel, dbusAck, stallCntClr,
    output dbusReq, dbusErr, pcStall, ifIdStall, ifIdFlush,
    output idExStall, idExFlush, exMemStall, memWbFlush, stallCnt
  );

  // Core side: supplies pipeline state, obeys stage controls.
  modport slave (
    output idRs1Addr, idRs2Addr, idRs1Used, idRs2Used,
    output exRdAddr, exRwen, exWbSel, exPcSel,
    output memMwen, memWbSel, dbusAck, stallCntClr,
    input  dbusReq, dbusErr, pcStall, ifIdStall, ifIdFlush,
    input  idExStall, idExFlush, exMemStall, memWbFlush, stallCnt
  );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the ID instruction and a load in EX.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result feeds the stall/flush priority mux.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic [4:0] rd_addr,
  input  logic       rwen,
  input  logic [1:0] wb_sel,
  output logic       load_use
);

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;

  // A load writing a real register whose result the ID instruction needs.
  always_comb begin
    ex_is_load = rwen & (wb_sel == WB_MEM) & (rd_addr != REG_ZERO);
    rs1_hit    = rs1_used & (rs1_addr == rd_addr);
    rs2_hit    = rs2_used & (rs2_addr == rd_addr);
    load_use   = ex_is_load & (rs1_hit | rs2_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage core plus data-bus wait/timeout FSM.
// Latency: stage controls are combinational; dbusErr is registered (1 cycle).
// Backpressure: a pending data-bus access freezes every stage until ack or timeout.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.master  bus
);

  // Last waitCnt value before the access is abandoned.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           state;
  logic [7:0]       wait_cnt;
  logic             dbus_err;
  logic [CNT_W-1:0] stall_cnt;

  logic             load_use;
  logic             mem_access;
  logic             mem_stall;
  logic             req_raw;
  logic             run;

  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_mem_stall;
  logic             mem_wb_flush;

  hazard_detect u_hazard (
    .rs1_addr (bus.idRs1Addr),
    .rs2_addr (bus.idRs2Addr),
    .rs1_used (bus.idRs1Used),
    .rs2_used (bus.idRs2Used),
    .rd_addr  (bus.exRdAddr),
    .rwen     (bus.exRwen),
    .wb_sel   (bus.exWbSel),
    .load_use (load_use)
  );

  // Bus request and memory stall from FSM state and the current handshake.
  always_comb begin
    mem_access = bus.memMwen | (bus.memWbSel == WB_MEM);
    req_raw    = 1'b0;
    mem_stall  = 1'b0;
    case (state)
      S_IDLE: begin
        req_raw   = mem_access;
        mem_stall = mem_access & ~bus.dbusAck;
      end
      S_WAIT: begin
        req_raw   = 1'b1;
        // Ack wins over timeout; the timeout cycle itself releases the stall.
        mem_stall = ~bus.dbusAck & (wait_cnt != WAIT_LAST);
      end
      default: begin
        req_raw   = 1'b0;
        mem_stall = 1'b0;
      end
    endcase
  end

  // Priority mux: memory stall, then EX redirect, then load-use bubble.
  always_comb begin
    run          = (rst != RESET);
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;
    if (run) begin
      if (mem_stall) begin
        // EX/ID inputs are frozen, so branch and load-use get re-evaluated later.
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (bus.exPcSel) begin
        // The ID instruction is wrong-path, so any load-use on it is moot.
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
      end else if (load_use) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_flush  = 1'b1;
      end
    end
  end

  // Data-bus FSM: track wait cycles, abandon at the limit and flag the error.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RESET) begin
      state    <= S_IDLE;
      wait_cnt <= 8'd0;
      dbus_err <= 1'b0;
    end else begin
      dbus_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mem_access & ~bus.dbusAck) begin
            state    <= S_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        S_WAIT: begin
          if (bus.dbusAck) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
            dbus_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state    <= S_IDLE;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

  // Stall-cycle counter: clear wins, otherwise count pcStall cycles and saturate.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RESET) begin
      stall_cnt <= '0;
    end else if (bus.stallCntClr) begin
      stall_cnt <= '0;
    end else if (pc_stall && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.dbusReq    = run & req_raw;
  assign bus.dbusErr    = dbus_err;
  assign bus.pcStall    = pc_stall;
  assign bus.ifIdStall  = if_id_stall;
  assign bus.ifIdFlush  = if_id_flush;
  assign bus.idExStall  = id_ex_stall;
  assign bus.idExFlush  = id_ex_flush;
  assign bus.exMemStall = ex_mem_stall;
  assign bus.memWbFlush = mem_wb_flush;
  assign bus.stallCnt   = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed plus random bench for pipe_ctrl against a cycle-level reference model.
// Latency: checks combinational controls each cycle and registered dbusErr/stallCnt.
// Backpressure: model counts stalled cycles per access to predict ack/timeout release.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int TO  = 16;
  localparam int CW  = 8;
  localparam int MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state: cycles the current access has stalled so far,
  // pending error flag and stall counter.
  int   m_stalled = 0;
  bit   m_err     = 1'b0;
  int   m_cnt     = 0;

  pipe_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    bus.idRs1Addr   = 5'd0;
    bus.idRs2Addr   = 5'd0;
    bus.idRs1Used   = 1'b0;
    bus.idRs2Used   = 1'b0;
    bus.exRdAddr    = 5'd0;
    bus.exRwen      = 1'b0;
    bus.exWbSel     = 2'b00;
    bus.exPcSel     = 1'b0;
    bus.memMwen     = 1'b0;
    bus.memWbSel    = 2'b00;
    bus.dbusAck     = 1'b0;
    bus.stallCntClr = 1'b0;
  endtask

  function automatic logic [7:0] ctl_obs();
    return {bus.dbusReq, bus.pcStall, bus.ifIdStall, bus.ifIdFlush,
            bus.idExStall, bus.idExFlush, bus.exMemStall, bus.memWbFlush};
  endfunction

  // One clock cycle: called just after a falling edge with inputs applied.
  task automatic tick(input string tag);
    bit active, ms, br, lu, hit, tmo, pcs;
    logic [7:0] exp;
    #1;
    active = (m_stalled > 0) || bus.memMwen || (bus.memWbSel == 2'b01);
    ms  = active && !bus.dbusAck && (m_stalled < TO - 1);
    tmo = active && !bus.dbusAck && (m_stalled == TO - 1);
    hit = (bus.idRs1Used && bus.idRs1Addr == bus.exRdAddr) ||
          (bus.idRs2Used && bus.idRs2Addr == bus.exRdAddr);
    br  = !ms && bus.exPcSel;
    lu  = !ms && !bus.exPcSel && bus.exRwen && bus.exWbSel == 2'b01 &&
          bus.exRdAddr != 5'd0 && hit;
    pcs = ms || lu;
    exp = {active, pcs, pcs, br, ms, br || lu, ms, ms};
    chk({tag, ".ctl"}, 64'(ctl_obs()), 64'(exp));
    chk({tag, ".cnt"}, 64'(bus.stallCnt), 64'(m_cnt));
    chk({tag, ".err"}, 64'(bus.dbusErr), 64'(m_err));
    @(posedge clk);
    m_stalled = ms ? m_stalled + 1 : 0;
    m_err     = tmo;
    if (bus.stallCntClr) m_cnt = 0;
    else if (pcs && m_cnt < MAX) m_cnt = m_cnt + 1;
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_stalled = 0;
    m_err     = 1'b0;
    m_cnt     = 0;
  endtask

  task automatic load_use_x5();
    bus.exRdAddr  = 5'd5;
    bus.exRwen    = 1'b1;
    bus.exWbSel   = WB_MEM;
    bus.idRs2Addr = 5'd5;
    bus.idRs2Used = 1'b1;
  endtask

  initial begin
    set_idle();
    // Reset state, with activity on the inputs that must not leak through.
    bus.memMwen = 1'b1;
    bus.exPcSel = 1'b1;
    load_use_x5();
    #12;
    chk("reset.ctl", 64'(ctl_obs()), 64'd0);
    chk("reset.cnt", 64'(bus.stallCnt), 64'd0);
    chk("reset.err", 64'(bus.dbusErr), 64'd0);
    @(negedge clk);
    set_idle();
    rst = 1'b1;
    model_reset();
    tick("idle0");

    // Load-use on rs2, then the load moves on.
    load_use_x5();
    tick("lu.hit");
    bus.exRwen = 1'b0;
    tick("lu.after");
    // Same pattern on x0 is no hazard.
    load_use_x5();
    bus.exRdAddr  = 5'd0;
    bus.idRs2Addr = 5'd0;
    tick("lu.x0");
    // rs1 match only.
    load_use_x5();
    bus.idRs2Used = 1'b0;
    bus.idRs1Addr = 5'd5;
    bus.idRs1Used = 1'b1;
    tick("lu.rs1");
    set_idle();

    // Redirect beats a simultaneous load-use.
    load_use_x5();
    bus.exPcSel = 1'b1;
    tick("br.over_lu");
    set_idle();
    tick("br.after");

    // Store acked in the request cycle: no stall.
    bus.memMwen = 1'b1;
    bus.dbusAck = 1'b1;
    tick("st.zero_wait");
    set_idle();
    tick("st.after");

    // Load acked after 3 wait cycles; load-use and branch ignored while stalled.
    bus.memWbSel = WB_MEM;
    tick("ld.w1");
    bus.exPcSel = 1'b1;
    tick("ld.w2");
    bus.exPcSel = 1'b0;
    load_use_x5();
    tick("ld.w3");
    bus.dbusAck = 1'b1;
    tick("ld.ack");
    set_idle();
    tick("ld.after");

    // No ack: 15 stalled cycles, release on the 16th, error pulse after.
    bus.memWbSel = WB_MEM;
    for (int i = 0; i < TO; i++) tick($sformatf("to.c%0d", i + 1));
    set_idle();
    tick("to.err");
    tick("to.quiet");

    // Reset asserted in the middle of a wait.
    bus.memWbSel = WB_MEM;
    for (int i = 0; i < 5; i++) tick($sformatf("rw.c%0d", i + 1));
    #2;
    rst = 1'b0;
    #1;
    chk("rw.ctl", 64'(ctl_obs()), 64'd0);
    chk("rw.cnt", 64'(bus.stallCnt), 64'd0);
    chk("rw.err", 64'(bus.dbusErr), 64'd0);
    @(negedge clk);
    model_reset();
    set_idle();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick($sformatf("rw.post%0d", i));

    // Clear wins over a concurrent stall.
    load_use_x5();
    tick("clr.pre");
    bus.stallCntClr = 1'b1;
    tick("clr.stall");
    bus.stallCntClr = 1'b0;
    tick("clr.post");

    // Counter saturation.
    for (int i = 0; i < MAX + 6; i++) tick("sat");
    bus.stallCntClr = 1'b1;
    tick("sat.clr");
    set_idle();
    tick("sat.after");

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      bus.idRs1Addr   = 5'($urandom_range(0, 3));
      bus.idRs2Addr   = 5'($urandom_range(0, 3));
      bus.idRs1Used   = 1'($urandom_range(0, 1));
      bus.idRs2Used   = 1'($urandom_range(0, 1));
      bus.exRdAddr    = 5'($urandom_range(0, 3));
      bus.exRwen      = 1'($urandom_range(0, 1));
      bus.exWbSel     = 2'($urandom_range(0, 3));
      bus.exPcSel     = ($urandom_range(0, 5) == 0);
      bus.memMwen     = ($urandom_range(0, 5) == 0);
      bus.memWbSel    = 2'($urandom_range(0, 3));
      bus.dbusAck     = ($urandom_range(0, 7) == 0);
      bus.stallCntClr = ($urandom_range(0, 31) == 0);
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
